// File: rtl/memory_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: request opcodes,
// response error codes, FSM states and small opcode classifiers.
package memory_access_unit_pkg;

  // Request opcodes as presented on req_op.
  typedef enum logic [2:0] {
    MEM_OP_LW  = 3'd0,
    MEM_OP_LH  = 3'd1,
    MEM_OP_LHU = 3'd2,
    MEM_OP_LB  = 3'd3,
    MEM_OP_LBU = 3'd4,
    MEM_OP_SW  = 3'd5,
    MEM_OP_SH  = 3'd6,
    MEM_OP_SB  = 3'd7
  } mem_op_e;

  // Response error codes as presented on resp_error.
  typedef enum logic [1:0] {
    MEM_ERR_NONE     = 2'd0,
    MEM_ERR_MISALIGN = 2'd1,
    MEM_ERR_RANGE    = 2'd2
  } mem_err_e;

  // Unit state: either free for a new request or finishing a sub-word store.
  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_RMW_WRITE = 1'b1
  } mau_state_e;

  // True for every opcode that returns data from memory.
  function automatic logic is_load(input mem_op_e op);
    logic result;
    case (op)
      MEM_OP_LW, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LB, MEM_OP_LBU: result = 1'b1;
      default:                                                 result = 1'b0;
    endcase
    return result;
  endfunction

  // True for the stores that need a read-modify-write of the whole word.
  function automatic logic is_sub_word_store(input mem_op_e op);
    logic result;
    case (op)
      MEM_OP_SH, MEM_OP_SB: result = 1'b1;
      default:              result = 1'b0;
    endcase
    return result;
  endfunction

  // Alignment rule: words need addr[1:0]==0, halfwords need addr[0]==0.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
    logic result;
    case (op)
      MEM_OP_LW, MEM_OP_SW:              result = (off != 2'b00);
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  result = off[0];
      default:                           result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/memory_access_unit_byte_lane_align.sv
// Combinational little-endian lane logic: extracts and extends a load
// result from a memory word, and merges a byte/halfword into a word for
// sub-word stores.
module byte_lane_align
  import memory_access_unit_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  byte_off_i,
  input  mem_op_e     op_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  // Select the addressed lane and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input mem_op_e     op);
    logic [15:0] half;
    logic [7:0]  lane;
    logic [31:0] result;
    half = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      2'd3:    lane = word[31:24];
      default: lane = word[7:0];
    endcase
    case (op)
      MEM_OP_LW:  result = word;
      MEM_OP_LH:  result = {{16{half[15]}}, half};
      MEM_OP_LHU: result = {16'h0000, half};
      MEM_OP_LB:  result = {{24{lane[7]}}, lane};
      MEM_OP_LBU: result = {24'h00_0000, lane};
      default:    result = 32'h0000_0000;
    endcase
    return result;
  endfunction

  // Replace the addressed byte/halfword of the current word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input mem_op_e     op);
    logic [31:0] result;
    result = word;
    case (op)
      MEM_OP_SW: result = wdata;
      MEM_OP_SH: begin
        if (off[1]) begin
          result[31:16] = wdata[15:0];
        end else begin
          result[15:0] = wdata[15:0];
        end
      end
      MEM_OP_SB: begin
        case (off)
          2'd0:    result[7:0]   = wdata[7:0];
          2'd1:    result[15:8]  = wdata[7:0];
          2'd2:    result[23:16] = wdata[7:0];
          2'd3:    result[31:24] = wdata[7:0];
          default: result        = word;
        endcase
      end
      default: result = word;
    endcase
    return result;
  endfunction

  assign load_data_o   = load_extract(rd_word_i, byte_off_i, op_i);
  assign merged_word_o = store_merge(rd_word_i, wdata_i, byte_off_i, op_i);

endmodule

// File: rtl/memory_access_unit.sv
// MEM-stage load/store unit in front of a word-addressed data_memory with a
// combinational read and negedge write commit. Loads and SW complete in one
// cycle; SB/SH read the word in the accept cycle and write the merged word
// in a second cycle, holding off the pipeline through req_ready.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error,
  output logic [29:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_input,
  input  logic [31:0] mem_read_result
);

  localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);

  mau_state_e  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] merged_q, merged_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  mem_err_e    resp_error_q, resp_error_d;

  mem_op_e     op_s;
  mem_err_e    err_s;
  logic        accept_s;
  logic        write_s;
  logic [29:0] mem_address_s;
  logic [31:0] write_word_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_word_s;

  assign op_s     = mem_op_e'(req_op);
  assign accept_s = (state_q == ST_IDLE) && req_valid;

  byte_lane_align u_lane (
    .rd_word_i     (mem_read_result),
    .wdata_i       (req_wdata),
    .byte_off_i    (req_addr[1:0]),
    .op_i          (op_s),
    .load_data_o   (load_data_s),
    .merged_word_o (merged_word_s)
  );

  // Classify the incoming request; misalignment outranks out-of-range.
  always_comb begin
    err_s = MEM_ERR_NONE;
    if (is_misaligned(op_s, req_addr[1:0])) begin
      err_s = MEM_ERR_MISALIGN;
    end else if (req_addr[31:2] >= DEPTH_WORDS) begin
      err_s = MEM_ERR_RANGE;
    end else begin
      err_s = MEM_ERR_NONE;
    end
  end

  // Drive the memory port: request address while idle, latched RMW word otherwise.
  always_comb begin
    mem_address_s = req_addr[31:2];
    write_word_s  = req_wdata;
    write_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (err_s == MEM_ERR_NONE) && (op_s == MEM_OP_SW)) begin
          write_s = 1'b1;
        end else begin
          write_s = 1'b0;
        end
      end
      ST_RMW_WRITE: begin
        mem_address_s = addr_q;
        write_word_s  = merged_q;
        write_s       = 1'b1;
      end
      default: begin
        write_s = 1'b0;
      end
    endcase
  end

  // Next-state and response computation for the two-state FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    merged_d     = merged_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    resp_error_d = MEM_ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (err_s != MEM_ERR_NONE) begin
            resp_valid_d = 1'b1;
            resp_error_d = err_s;
          end else if (is_sub_word_store(op_s)) begin
            addr_d   = req_addr[31:2];
            merged_d = merged_word_s;
            state_d  = ST_RMW_WRITE;
          end else if (is_load(op_s)) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data_s;
          end else begin
            resp_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RMW_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered response outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= 30'h0000_0000;
      merged_q     <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_error_q <= MEM_ERR_NONE;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      merged_q     <= merged_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Gating by reset_n guarantees no write lands while reset is asserted,
  // including an abandoned RMW write.
  assign mem_write_enable = write_s & reset_n;
  assign mem_address      = mem_address_s;
  assign mem_write_input  = write_word_s;
  assign req_ready        = (state_q == ST_IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;

endmodule
